// File: rtl/decode_fwd_stage_if.sv
// ---------------------------------------------------------------------------
// decode_fwd_stage_if
//   Handshake bundle around the decode/operand-fetch stage: the fetch-side
//   input channel (in_*) and the execute-side output slot (out_*).
//
//   modport master : the decode stage itself. It accepts in_* and drives
//                    in_ready, and it drives the out_* slot while sampling
//                    out_ready.
//   modport slave  : the surrounding pipeline. Fetch drives in_*, and
//                    execute consumes out_* and drives out_ready.
// ---------------------------------------------------------------------------
interface decode_fwd_stage_if #(
  parameter int XLEN = 64
);
  // fetch -> decode
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  // decode -> execute
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_dst;
  logic [XLEN-1:0] out_srca;
  logic [XLEN-1:0] out_srcb;

  modport master (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
           out_rs1, out_rs2, out_dst, out_srca, out_srcb
  );

  modport slave (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
           out_rs1, out_rs2, out_dst, out_srca, out_srcb
  );
endinterface

// File: rtl/decode_fwd_stage.sv
// ---------------------------------------------------------------------------
// decode_fwd_stage
//   Decode / operand-fetch stage. It captures a fetched instruction, reads
//   rs1/rs2 from the register file and resolves each operand against
//   NUM_FWD forwarding sources. Source 0 is the youngest and wins. The
//   resolved instruction is held in a registered output slot with a
//   valid/ready handshake. A load-use hazard (the winning source is still
//   pending) stalls the input. flush kills both the held and the incoming
//   instruction.
//
// Ports
//   clk, resetn   clock (rising edge), asynchronous active-low reset
//   bus           decode_fwd_stage_if.master : in_* / out_* handshake
//   ra1, ra2      register-file read addresses (combinational)
//   rd1, rd2      register-file read data (same cycle)
//   fwd_valid     per-source live destination write
//   fwd_dst       per-source destination register, 5 bits each
//   fwd_pending   per-source result not yet available
//   fwd_data      per-source result, XLEN bits each
//   flush         kill held and incoming instruction
//   hazard        load-use stall active this cycle (combinational)
//   stall_cnt     saturating count of hazard cycles
// ---------------------------------------------------------------------------
module decode_fwd_stage #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  decode_fwd_stage_if.master      bus,
  output logic [4:0]              ra1,
  output logic [4:0]              ra2,
  input  logic [XLEN-1:0]         rd1,
  input  logic [XLEN-1:0]         rd2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_dst,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    flush,
  output logic                    hazard,
  output logic [15:0]             stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic            blocked;
  } operand_t;

  // The priority pick comes first: the lowest matching index decides the
  // operand. Its pending bit then decides whether the operand is usable.
  // A pending young source therefore blocks even when an older source
  // holds the same register with a ready value.
  function automatic operand_t resolve(
    input logic [4:0]              rs,
    input logic [XLEN-1:0]         rf_data,
    input logic [NUM_FWD-1:0]      f_valid,
    input logic [NUM_FWD*5-1:0]    f_dst,
    input logic [NUM_FWD-1:0]      f_pending,
    input logic [NUM_FWD*XLEN-1:0] f_data
  );
    operand_t res;
    logic     hit;
    res.val     = rf_data;
    res.blocked = 1'b0;
    hit         = 1'b0;
    if (rs == 5'd0) begin
      // x0 is hard-wired to zero and never matches a forwarding source.
      res.val = '0;
    end else begin
      for (int j = 0; j < NUM_FWD; j++) begin
        if (!hit && f_valid[j] && (f_dst[j*5 +: 5] == rs)) begin
          hit         = 1'b1;
          res.val     = f_data[j*XLEN +: XLEN];
          res.blocked = f_pending[j];
        end
      end
    end
    return res;
  endfunction

  // Output slot state
  logic            valid_q,     valid_d;
  logic [31:0]     instr_q,     instr_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] srca_q,      srca_d;
  logic [XLEN-1:0] srcb_q,      srcb_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [4:0] rs1, rs2;
  operand_t   opa, opb;
  logic       in_ready;
  logic       capture;

  assign rs1 = bus.in_instr[19:15];
  assign rs2 = bus.in_instr[24:20];
  assign ra1 = rs1;
  assign ra2 = rs2;

  // Operand resolution and handshake
  always_comb begin
    opa      = resolve(rs1, rd1, fwd_valid, fwd_dst, fwd_pending, fwd_data);
    opb      = resolve(rs2, rd2, fwd_valid, fwd_dst, fwd_pending, fwd_data);
    hazard   = bus.in_valid && (opa.blocked || opb.blocked);
    // The slot is free when it is empty or being drained this cycle.
    in_ready = (!valid_q || bus.out_ready) && !hazard && !flush;
    capture  = bus.in_valid && in_ready;
  end

  assign bus.in_ready = in_ready;

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    stall_cnt_d = stall_cnt_q;

    if (hazard && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // flush beats capture and hold. Stale data fields are harmless
    // because valid_q is cleared.
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      instr_d = bus.in_instr;
      pc_d    = bus.in_pc;
      srca_d  = opa.val;
      srcb_d  = opb.val;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the data fields are reset as well as valid, because execute
      // must see an all-zero slot after reset. Drop this only for
      // registers whose contents are never observed while invalid.
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so that every flop samples its
      // pre-edge value regardless of statement order.
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_rs1   = instr_q[19:15];
  assign bus.out_rs2   = instr_q[24:20];
  assign bus.out_dst   = instr_q[11:7];
  assign bus.out_srca  = srca_q;
  assign bus.out_srcb  = srcb_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_decode_fwd_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_fwd_stage
//   Self-checking bench for decode_fwd_stage with NUM_FWD = 3 and XLEN = 64.
//   Inputs change on the falling edge. Combinational outputs are compared
//   1 time unit later, and registered outputs 1 time unit after the rising
//   edge. Expected values come from a behavioural model of the output slot
//   and the stall counter.
// ---------------------------------------------------------------------------
module tb_decode_fwd_stage;
  localparam int NF = 3;
  localparam int XL = 64;

  logic clk = 1'b0;
  logic resetn;

  decode_fwd_stage_if #(.XLEN(XL)) bus ();

  logic [4:0]         ra1, ra2;
  logic [XL-1:0]      rd1, rd2;
  logic [NF-1:0]      fwd_valid, fwd_pending;
  logic [NF*5-1:0]    fwd_dst;
  logic [NF*XL-1:0]   fwd_data;
  logic               flush, hazard;
  logic [15:0]        stall_cnt;
  logic [XL-1:0]      regfile [32];

  assign rd1 = regfile[ra1];
  assign rd2 = regfile[ra2];

  decode_fwd_stage #(.NUM_FWD(NF), .XLEN(XL)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .fwd_valid   (fwd_valid),
    .fwd_dst     (fwd_dst),
    .fwd_pending (fwd_pending),
    .fwd_data    (fwd_data),
    .flush       (flush),
    .hazard      (hazard),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_instr;
  logic [XL-1:0] m_pc, m_srca, m_srcb;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] make_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic set_fwd(input int j, input bit v, input logic [4:0] dst, input bit pend,
                         input logic [XL-1:0] data);
    fwd_valid[j]          = v;
    fwd_dst[j*5 +: 5]     = dst;
    fwd_pending[j]        = pend;
    fwd_data[j*XL +: XL]  = data;
  endtask

  task automatic clear_fwd();
    for (int j = 0; j < NF; j++) set_fwd(j, 1'b0, 5'd0, 1'b0, '0);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = '0;
    m_pc    = '0;
    m_srca  = '0;
    m_srcb  = '0;
    m_cnt   = 0;
  endtask

  // Operand rule: x0 reads zero. Otherwise the first matching source
  // decides, and it is unresolved if that source is still pending. With
  // no match the register file supplies the value.
  task automatic model_operand(input logic [4:0] rs, input logic [XL-1:0] rf,
                               output logic [XL-1:0] v, output bit unres);
    int hit;
    hit   = -1;
    v     = rf;
    unres = 1'b0;
    if (rs == 5'd0) begin
      v = '0;
    end else begin
      for (int j = 0; j < NF; j++)
        if (hit < 0 && fwd_valid[j] && fwd_dst[j*5 +: 5] == rs) hit = j;
      if (hit >= 0) begin
        unres = fwd_pending[hit];
        v     = fwd_data[hit*XL +: XL];
      end
    end
  endtask

  task automatic check_slot();
    check("out_valid", bus.out_valid, m_valid);
    check("stall_cnt", stall_cnt, m_cnt[15:0]);
    if (m_valid) begin
      check("out_instr", bus.out_instr, m_instr);
      check("out_pc",    bus.out_pc,    m_pc);
      check("out_rs1",   bus.out_rs1,   m_instr[19:15]);
      check("out_rs2",   bus.out_rs2,   m_instr[24:20]);
      check("out_dst",   bus.out_dst,   m_instr[11:7]);
      check("out_srca",  bus.out_srca,  m_srca);
      check("out_srcb",  bus.out_srcb,  m_srcb);
    end
  endtask

  // One clock cycle, entered and left on the falling edge with inputs
  // already driven.
  task automatic cycle(input bit chk);
    logic [XL-1:0] a, b;
    bit            ua, ub, hz, rdy, cap;
    logic [4:0]    r1, r2;
    #1;
    r1 = bus.in_instr[19:15];
    r2 = bus.in_instr[24:20];
    model_operand(r1, regfile[r1], a, ua);
    model_operand(r2, regfile[r2], b, ub);
    hz  = bus.in_valid && (ua || ub);
    rdy = (!m_valid || bus.out_ready) && !hz && !flush;
    cap = bus.in_valid && rdy;
    if (chk) begin
      check("ra1",      ra1,          r1);
      check("ra2",      ra2,          r2);
      check("hazard",   hazard,       hz);
      check("in_ready", bus.in_ready, rdy);
    end
    @(posedge clk);
    if (hz && m_cnt < 65535) m_cnt++;
    if (flush) begin
      m_valid = 1'b0;
    end else if (cap) begin
      m_valid = 1'b1;
      m_instr = bus.in_instr;
      m_pc    = bus.in_pc;
      m_srca  = a;
      m_srcb  = b;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    if (chk) check_slot();
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    logic [31:0] ins;
    ins           = $urandom;
    ins[19:15]    = 5'($urandom_range(7));
    ins[24:20]    = 5'($urandom_range(7));
    bus.in_instr  = ins;
    bus.in_valid  = ($urandom_range(3) != 0);
    bus.in_pc     = {$urandom, $urandom};
    bus.out_ready = ($urandom_range(3) != 0);
    flush         = ($urandom_range(15) == 0);
    for (int j = 0; j < NF; j++)
      set_fwd(j, $urandom_range(3) != 0, 5'($urandom_range(7)), $urandom_range(3) == 0,
              {$urandom, $urandom});
  endtask

  initial begin
    // ---------------- reset ----------------
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    clear_fwd();
    for (int i = 0; i < 32; i++) regfile[i] = {$urandom, $urandom};
    regfile[0] = 64'hDEAD_0000_DEAD_0000;   // must never be read through
    regfile[5] = 64'h1234;
    model_reset();
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    check("rst_out_srca",  bus.out_srca, 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    // ---------------- priority ----------------
    bus.in_valid = 1'b1;
    bus.in_instr = make_instr(5'd5, 5'd0, 5'd3);
    bus.in_pc    = 64'h1000;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 64'hAAAA);
    set_fwd(1, 1'b1, 5'd9, 1'b0, 64'hCCCC);
    set_fwd(2, 1'b1, 5'd5, 1'b0, 64'hBBBB);
    cycle(1'b1);
    check("prio_srca", bus.out_srca, 64'hAAAA);
    check("prio_srcb", bus.out_srcb, 64'h0);

    // ---------------- load-use ----------------
    bus.in_instr = make_instr(5'd1, 5'd7, 5'd4);
    bus.in_pc    = 64'h1004;
    clear_fwd();
    set_fwd(0, 1'b1, 5'd7, 1'b1, 64'h0);
    set_fwd(1, 1'b1, 5'd7, 1'b0, 64'h9999);  // older ready copy must not bypass the stall
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      check("lu_hazard",   hazard,       1'b1);
      check("lu_in_ready", bus.in_ready, 1'b0);
    end
    check("lu_stall_cnt", stall_cnt, 16'd3);
    set_fwd(0, 1'b1, 5'd7, 1'b0, 64'h55);
    cycle(1'b1);
    check("lu_out_valid", bus.out_valid, 1'b1);
    check("lu_srcb",      bus.out_srcb,  64'h55);

    // ---------------- backpressure ----------------
    clear_fwd();
    set_fwd(0, 1'b1, 5'd5, 1'b0, 64'h1111);
    bus.in_instr  = make_instr(5'd5, 5'd6, 5'd8);
    bus.in_pc     = 64'h1008;
    bus.out_ready = 1'b1;
    cycle(1'b1);
    bus.out_ready = 1'b0;
    bus.in_instr  = make_instr(5'd6, 5'd5, 5'd9);
    bus.in_pc     = 64'h100C;
    for (int i = 0; i < 4; i++) begin
      set_fwd(0, 1'b1, 5'd5, 1'b0, {$urandom, $urandom});
      cycle(1'b1);
      check("bp_srca",     bus.out_srca,  64'h1111);
      check("bp_in_ready", bus.in_ready,  1'b0);
    end
    bus.out_ready = 1'b1;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 64'h2222);
    cycle(1'b1);
    check("bp_reload_valid", bus.out_valid, 1'b1);
    check("bp_reload_pc",    bus.out_pc,    64'h100C);
    check("bp_reload_srcb",  bus.out_srcb,  64'h2222);

    // ---------------- flush ----------------
    bus.out_ready = 1'b0;
    bus.in_instr  = make_instr(5'd2, 5'd3, 5'd10);
    bus.in_pc     = 64'h1010;
    flush         = 1'b1;
    cycle(1'b1);
    check("flush_valid", bus.out_valid, 1'b0);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle(1'b1);
    check("flush_no_emit", bus.out_valid, 1'b0);

    // ---------------- async reset mid-capture ----------------
    bus.in_valid = 1'b1;
    bus.in_instr = make_instr(5'd2, 5'd3, 5'd11);
    bus.in_pc    = 64'h1014;
    cycle(1'b1);                            // slot occupied, stall_cnt = 3
    bus.in_instr = make_instr(5'd4, 5'd6, 5'd12);
    bus.in_pc    = 64'h1018;
    #2 resetn = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_stall_cnt", stall_cnt,     16'h0);
    check("arst_out_instr", bus.out_instr, 32'h0);
    check("arst_out_srcb",  bus.out_srcb,  64'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b1);
    check("post_rst_instr", bus.out_instr, make_instr(5'd4, 5'd6, 5'd12));

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      cycle(1'b1);
    end

    // ---------------- stall counter saturation ----------------
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    resetn        = 1'b0;
    model_reset();
    @(negedge clk);
    resetn       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = make_instr(5'd7, 5'd0, 5'd1);
    clear_fwd();
    set_fwd(0, 1'b1, 5'd7, 1'b1, 64'h0);
    for (int i = 0; i < 65534; i++) cycle(1'b0);
    check("sat_preload", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    check("sat_hold", stall_cnt, 16'hFFFF);
    cycle(1'b1);
    check("sat_no_wrap", stall_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_fwd_stage.md
# decode_fwd_stage

Parametrised decode/operand-fetch stage: captures a fetched instruction, reads rs1/rs2 from the register file, and resolves each operand against any number of forwarding sources. Operands come from the lowest-indexed (youngest) matching source. Holds the result in a registered output slot with a valid/ready handshake. It sits between fetch and execute and generalises the fixed two-source, unregistered decode path with three additions: N sources, load-use stall detection, and flush support.

## Interface
- NUM_FWD, 2: number of forwarding sources. Index 0 is youngest and has the highest priority.
- XLEN, 64: data width.
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- ra1, ra2  out  5  register-file read addresses: in_instr[19:15] and in_instr[24:20], combinational
- rd1, rd2  in  XLEN  register-file read data, same cycle
- fwd_valid  in  NUM_FWD  source j holds a live destination write
- fwd_dst  in  NUM_FWD×5  destination register of source j
- fwd_pending  in  NUM_FWD  source j result not yet available (load in flight)
- fwd_data  in  NUM_FWD×XLEN  result of source j
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  output slot occupied
- out_ready  in  1  execute accepts the output
- out_instr  out  32 ; out_pc  out  XLEN ; out_rs1, out_rs2, out_dst  out  5
- out_srca, out_srcb  out  XLEN  resolved operands
- hazard  out  1  load-use stall active this cycle, combinational
- stall_cnt  out  16  saturating count of hazard cycles

## Operation
- Operand resolution, evaluated independently for rs = rs1 and rs = rs2:
  - If rs == 0, the operand is 0. x0 never matches a forwarding source.
  - Otherwise find the lowest j with fwd_valid[j] && fwd_dst[j] == rs.
    - If found and fwd_pending[j] == 1, the operand is unresolved.
    - If found and not pending, the operand is fwd_data[j].
    - If no source matches, the operand is rd1 (or rd2).
  - A pending match at index j blocks the operand even when a higher index also matches. Priority picks first, then pending is checked.
- hazard = in_valid && (rs1 unresolved || rs2 unresolved). Both fields are always checked; no opcode-based masking.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Capture: when in_valid && in_ready, the output slot loads all in_* fields and both resolved operands, and sets out_valid = 1.
- Drain: when out_valid && out_ready and no capture occurs, out_valid clears to 0.
- Hold: when out_valid && !out_ready, every out_* field is frozen. Operands are not re-resolved after capture.
- Flush: out_valid clears to 0 on the next edge, and nothing is captured that cycle. Flush takes priority over capture and hold. out_* data fields may keep stale values.
- stall_cnt increments by 1 on every clock edge where hazard == 1. It saturates at 0xFFFF and never wraps.
- Reset (resetn low, asynchronous, effective at any point in a transaction):
  - out_valid = 0, stall_cnt = 0.
  - All out_* data fields are cleared to 0.
  - Combinational outputs follow their inputs.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k appears on out_* after edge k.
- Back-to-back throughput is 1 instruction per cycle while out_ready stays high.
- in_ready, hazard, ra1 and ra2 are combinational from the current-cycle inputs. Forwarding inputs are sampled in the same cycle as capture.
- Simultaneous drain and capture in one cycle: the slot reloads and out_valid stays 1.
- A hazard clears in the first cycle the matching source drops fwd_pending or moves out of priority. Capture occurs on that edge.
- Deassertion of resetn is taken synchronously to clk by the surrounding logic. The first capture is allowed on the first edge after release.

## Test plan
- Reset: drive resetn low mid-capture with in_valid = 1 → out_valid = 0 and stall_cnt = 0 immediately, before any clock edge. After release, the first instruction appears on out_* one cycle after acceptance.
- Priority: NUM_FWD = 3; rs1 = x5, rs2 = x0; sources 0 and 2 both target x5 with data 0xAAAA and 0xBBBB → out_srca = 0xAAAA, out_srcb = 0. rd1 = 0x1234 is ignored.
- Load-use: source 0 targets x7 with fwd_pending = 1; instruction uses rs2 = x7.
  - For 3 cycles: hazard = 1 and in_ready = 0, and stall_cnt = 3.
  - Then drop pending with fwd_data = 0x55 → out_srcb = 0x55 one cycle later.
- Backpressure: hold out_ready = 0 for 4 cycles while fwd_data changes → out_* stays frozen and in_ready = 0. Raise out_ready while a new instruction is presented → drain and capture occur in the same cycle, and out_valid stays 1.
- Flush: assert flush together with in_valid = 1 while the slot holds an instruction → out_valid = 0 next cycle and the incoming instruction is never emitted.
- Saturation: preload stall_cnt = 0xFFFE via 65534 hazard cycles, then 3 more hazard cycles → stall_cnt = 0xFFFF and it stays there.
